div_clocked_32bit: RTL and testbench

DIV_CLOCKED_32BIT -- requirements
Module: div_clocked_32bit

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 21 ++
 rtl/div_clocked_32bit.sv | 114 +++++++++++
 tb/tb_div_clocked_32bit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the clocked restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, try the subtract.
module div_step #(
    parameter int width = 32
) (
    input  logic [width-1:0] rem_in,
    input  logic             bit_in,
    input  logic [width-1:0] divisor,
    output logic [width-1:0] rem_out,
    output logic             q_bit
);

    logic [width:0] partial;
    logic [width:0] diff;

    // partial < 2*divisor whenever rem_in < divisor, so a clear MSB of diff means "fits"
    assign partial = {rem_in, bit_in};
    assign diff    = partial - {1'b0, divisor};
    assign q_bit   = ~diff[width];
    assign rem_out = q_bit ? diff[width-1:0] : partial[width-1:0];

endmodule

// File: rtl/div_clocked_32bit.sv
// Fixed-latency multi-cycle restoring divider (width steps + one writeback cycle, then ack).
// Optional signed support is enabled with the DIV_SIGNED_EN macro.
module div_clocked_32bit
    import div_pkg::*;
#(
    parameter int width = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic             ack,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder
);

    localparam int CW = $clog2(width + 1);

    div_state_t       state, nxt_state;
    logic [CW-1:0]    cnt;
    logic [width-1:0] rem_q, dvd_q, dsr_q;
    logic [width-1:0] step_rem;
    logic             step_q;
    logic [width-1:0] mag_a, mag_b, q_fix, r_fix;

    div_step #(.width(width)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[width-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

`ifdef DIV_SIGNED_EN
    logic neg_a, neg_b, neg_q_q, neg_r_q;

    assign neg_a = signed_op & a[width-1];
    assign neg_b = signed_op & b[width-1];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;
    // divide by zero keeps the all-ones quotient; remainder -|a| restores a
    assign q_fix = neg_q_q ? -dvd_q : dvd_q;
    assign r_fix = neg_r_q ? -rem_q : rem_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (state == IDLE && req) begin
            neg_q_q <= (neg_a ^ neg_b) && (b != '0);
            neg_r_q <= neg_a;
        end
    end
`else
    assign mag_a = a;
    assign mag_b = b;
    assign q_fix = dvd_q;
    assign r_fix = rem_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (req) nxt_state = BUSY;
            BUSY:    if (cnt == '0) nxt_state = DONE;
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        ack = (state == DONE);
    end

    // dvd_q shifts the dividend out MSB-first while quotient bits shift in at the LSB
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    cnt   <= CW'(width);
                    rem_q <= '0;
                    dvd_q <= mag_a;
                    dsr_q <= mag_b;
                end
                BUSY: if (cnt != '0) begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[width-2:0], step_q};
                    cnt   <= cnt - 1'b1;
                end else begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_clocked_32bit.sv
// Randomized + directed bench for div_clocked_32bit against an arithmetic reference model.
module tb_div_clocked_32bit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        ack;
    logic [31:0] quotient, remainder;
`ifdef DIV_SIGNED_EN
    logic        signed_op = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    div_clocked_32bit #(.width(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
`ifdef DIV_SIGNED_EN
        .signed_op (signed_op),
`endif
        .a         (a),
        .b         (b),
        .ack       (ack),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] av, input logic [31:0] bv, input bit sg,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (bv == 0) begin
            q = '1;
            r = av;
        end else if (sg) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = av / bv;
            r = av % bv;
        end
    endfunction

    // Starts a divide right away (caller sits #1 after an edge) and checks latency and results.
    task automatic do_div(input logic [31:0] av, input logic [31:0] bv, input bit sg, input string tag);
        logic [31:0] eq, er, prev_q, prev_r;
        int lat, glitch;
        model(av, bv, sg, eq, er);
        prev_q = quotient;
        prev_r = remainder;
        a = av;
        b = bv;
`ifdef DIV_SIGNED_EN
        signed_op = sg;
`endif
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        glitch = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = k;
                break;
            end
            if (quotient !== prev_q || remainder !== prev_r) glitch++;
        end
        chk($sformatf("%s latency", tag), lat, 33);
        chk($sformatf("%s hold", tag), glitch, 0);
        chk($sformatf("%s quotient", tag), quotient, eq);
        chk($sformatf("%s remainder", tag), remainder, er);
        @(posedge clk); #1;
        chk($sformatf("%s ack_drop", tag), {31'b0, ack}, 0);
        chk($sformatf("%s q_after", tag), quotient, eq);
    endtask

    initial begin
        int acks;
        logic [31:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        chk("reset ack", {31'b0, ack}, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        rst = 1'b1;

        do_div(32'd100, 32'd7, 1'b0, "basic");
        do_div(32'd4294961295, 32'd12345, 1'b0, "large");
        do_div(32'd15, 32'd4, 1'b0, "small");
        do_div(32'd15, 32'd0, 1'b0, "divzero");
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, "by_one");
        do_div(32'd3, 32'hFFFF_FFFF, 1'b0, "tiny");

        // second req ten cycles into a divide must be dropped
        a = 32'd60; b = 32'd4; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        a = 32'd9; b = 32'd3; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        acks = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        chk("busy ack_count", acks, 1);
        chk("busy quotient", quotient, 32'd15);
        chk("busy remainder", remainder, 32'd0);

        // reset in flight: no ack, outputs cleared
        a = 32'd1000; b = 32'd3; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort quotient", quotient, 0);
        chk("abort remainder", remainder, 0);
        acks = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        chk("abort ack_count", acks, 0);
        do_div(32'd1000, 32'd3, 1'b0, "after_abort");

        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 1) rb = rb >> $urandom_range(31, 16);
            if (i % 8 == 5) rb = 32'd0;
            do_div(ra, rb, 1'b0, $sformatf("rand%0d", i));
        end

`ifdef DIV_SIGNED_EN
        do_div(-32'sd7, 32'sd2, 1'b1, "s_neg7_2");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
        do_div(-32'sd15, 32'd0, 1'b1, "s_divzero");
        do_div(32'sd7, -32'sd2, 1'b1, "s_7_neg2");
        for (int i = 0; i < 15; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(30, 0);
            if ($urandom_range(1, 0) == 1) rb = -rb;
            do_div(ra, rb, 1'b1, $sformatf("srand%0d", i));
        end
        do_div(32'hFFFF_FFF9, 32'd2, 1'b0, "u_after_signed");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
